// File: rtl/sw_rr_arbiter_if.sv
// Handshake bundle between the switch FIFOs/output mux and the round-robin arbiter.
// The master modport is the arbiter side. The slave modport is the FIFO/mux side.
interface sw_rr_arbiter_if #(
    parameter int NUM_SW_INST = 5
);
    localparam int IDW = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;

    logic [NUM_SW_INST-1:0] fifo_empty;
    logic                   dst_ready;
    logic [NUM_SW_INST-1:0] sel;
    logic [NUM_SW_INST-1:0] fifo_rd;
    logic [IDW-1:0]         grant_id;
    logic                   data_valid;

    modport master (
        input  fifo_empty,
        input  dst_ready,
        output sel,
        output fifo_rd,
        output grant_id,
        output data_valid
    );

    modport slave (
        output fifo_empty,
        output dst_ready,
        input  sel,
        input  fifo_rd,
        input  grant_id,
        input  data_valid
    );
endinterface

// File: rtl/sw_rr_arbiter.sv
// Round-robin burst arbiter in front of the switch output mux: picks a non-empty FWFT FIFO,
// drives the one-hot mux select, pops it for up to MAX_BURST words and flags mux output validity.
module sw_rr_arbiter #(
    parameter int NUM_SW_INST = 5,
    parameter int MAX_BURST   = 4,
    parameter int MUX_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    sw_rr_arbiter_if.master   bus
);

  localparam int IDW = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;
  localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [IDW:0]   N_EXT     = (IDW+1)'(NUM_SW_INST);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_SW_INST - 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                 state_r;
  logic [NUM_SW_INST-1:0] sel_r;
  logic [IDW-1:0]         grant_id_r;
  logic [IDW-1:0]         ptr_r;
  logic [BCW-1:0]         burst_cnt_r;
  logic [MUX_LATENCY-1:0] vpipe_r;

  logic [IDW:0]           idx_s;
  logic                   found_s;
  logic [IDW-1:0]         win_s;
  logic [NUM_SW_INST-1:0] win_onehot_s;
  logic [NUM_SW_INST-1:0] fifo_rd_s;
  logic                   grant_empty_s;
  logic                   pop_s;
  logic                   release_s;
  logic [IDW-1:0]         next_ptr_s;

  // Rotating priority search starting at ptr; modulo wrap is done by subtraction so any count works.
  always_comb begin
    found_s = 1'b0;
    win_s   = {IDW{1'b0}};
    idx_s   = {(IDW+1){1'b0}};
    for (int k = 0; k < NUM_SW_INST; k++) begin
      idx_s = {1'b0, ptr_r} + (IDW+1)'(k);
      if (idx_s >= N_EXT) begin
        idx_s = idx_s - N_EXT;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && !bus.fifo_empty[idx_s[IDW-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[IDW-1:0];
      end else begin
        found_s = found_s;
      end
    end
    win_onehot_s = {{(NUM_SW_INST-1){1'b0}}, 1'b1} << win_s;
  end

  // Pop strobe and release decision for the current grant.
  always_comb begin
    fifo_rd_s     = {NUM_SW_INST{1'b0}};
    grant_empty_s = 1'b0;
    if (state_r == ST_GRANT) begin
      fifo_rd_s     = sel_r & ~bus.fifo_empty & {NUM_SW_INST{bus.dst_ready}};
      grant_empty_s = |(sel_r & bus.fifo_empty);
    end else begin
      fifo_rd_s     = {NUM_SW_INST{1'b0}};
      grant_empty_s = 1'b0;
    end
    pop_s      = |fifo_rd_s;
    release_s  = grant_empty_s | (pop_s & (burst_cnt_r == LAST_BEAT));
    next_ptr_s = (grant_id_r == LAST_ID) ? {IDW{1'b0}} : grant_id_r + IDW'(1);
  end

  // Arbitration FSM: IDLE picks a winner, GRANT bursts until the limit or the FIFO runs dry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      sel_r       <= {NUM_SW_INST{1'b0}};
      grant_id_r  <= {IDW{1'b0}};
      ptr_r       <= {IDW{1'b0}};
      burst_cnt_r <= {BCW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            sel_r       <= win_onehot_s;
            grant_id_r  <= win_s;
            burst_cnt_r <= {BCW{1'b0}};
            state_r     <= ST_GRANT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (release_s) begin
            sel_r   <= {NUM_SW_INST{1'b0}};
            ptr_r   <= next_ptr_s;
            state_r <= ST_IDLE;
          end else if (pop_s) begin
            burst_cnt_r <= burst_cnt_r + BCW'(1);
          end else begin
            state_r <= ST_GRANT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          sel_r   <= {NUM_SW_INST{1'b0}};
        end
      endcase
    end
  end

  // Delays each pop by the mux latency so data_valid lines up with the registered data_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe_r <= {MUX_LATENCY{1'b0}};
    end else begin
      vpipe_r[0] <= pop_s;
      for (int i = 1; i < MUX_LATENCY; i++) begin
        vpipe_r[i] <= vpipe_r[i-1];
      end
    end
  end

  assign bus.sel        = sel_r;
  assign bus.fifo_rd    = fifo_rd_s;
  assign bus.grant_id   = grant_id_r;
  assign bus.data_valid = vpipe_r[MUX_LATENCY-1];

endmodule

// File: doc/sw_rr_arbiter.md
Name: sw_rr_arbiter

Overview:
- Round-robin arbiter sitting directly upstream of the switch output mux.
- Watches the empty flags of NUM_SW_INST per-switch first-word-fall-through (FWFT) FIFOs and picks one source at a time.
- Drives the mux's one-hot sel and pops the granted FIFO.
- Produces a data_valid strobe aligned with the mux's registered data_out.
- Grants are held for bursts of up to MAX_BURST words to amortise arbitration.

Parameters:
- NUM_SW_INST, 5: number of switch FIFOs (mux inputs); must be >= 2.
- MAX_BURST, 4: maximum words transferred per grant; must be >= 1.
- MUX_LATENCY, 1: cycles from sel/FIFO data to the mux's data_out; sets the data_valid delay; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  NUM_SW_INST  per-source FIFO empty flag, bit i = FIFO i.
- dst_ready  in  1  downstream can accept a word this cycle.
- sel  out  NUM_SW_INST  registered one-hot mux select; all-zero when idle.
- fifo_rd  out  NUM_SW_INST  combinational pop strobe per FIFO.
- grant_id  out  max(1,$clog2(NUM_SW_INST))  binary index of the current/last granted source.
- data_valid  out  1  data_out of the mux holds a valid word this cycle.

Behaviour:
- Reset (async, rst=1) clears immediately:
  - state=IDLE, sel=0, fifo_rd=0, grant_id=0, data_valid=0.
  - Priority pointer ptr=0, burst_cnt=0, valid delay pipe all zero.
  - Any in-flight data_valid is discarded.
- FSM states: IDLE and GRANT.
- IDLE:
  - sel=0, fifo_rd=0.
  - Search order is ptr, ptr+1, ..., wrapping from NUM_SW_INST-1 to 0. The winner is the first index with fifo_empty=0.
  - If a winner exists, at the next edge: sel<=onehot(winner), grant_id<=winner, burst_cnt<=0, state<=GRANT.
  - Arbitration ignores dst_ready.
  - If all FIFOs are empty, remain in IDLE.
- GRANT:
  - fifo_rd = sel & ~fifo_empty & {NUM_SW_INST{dst_ready}}.
  - A transfer occurs in any cycle where fifo_rd is nonzero.
  - Transfer with burst_cnt < MAX_BURST-1: burst_cnt++, stay in GRANT.
  - Transfer with burst_cnt == MAX_BURST-1: release.
  - Granted fifo_empty=1 (no transfer possible): release in that cycle, regardless of dst_ready.
  - dst_ready=0 with granted FIFO non-empty: hold. sel, burst_cnt and state are unchanged and there is no pop.
- Release, at the next edge:
  - sel<=0, state<=IDLE, ptr<=(grant_id+1) mod NUM_SW_INST. The wrap is explicit; NUM_SW_INST need not be a power of 2.
  - grant_id keeps its value.
  - Every grant costs exactly one IDLE bubble cycle before the next grant.
- data_valid:
  - data_valid = (|fifo_rd) delayed by exactly MUX_LATENCY cycles through a shift register.
  - Each pop yields exactly one data_valid pulse.
- Invariants (for assertions):
  - sel is always zero or one-hot.
  - fifo_rd is a subset of sel.
  - fifo_rd is never asserted for an empty FIFO.
  - sel is stable throughout a GRANT.
  - At most MAX_BURST pops occur per grant.
- Fairness: with all sources continuously non-empty, grants rotate strictly 0,1,...,N-1,0.
- Simultaneous events:
  - Last-burst transfer and fifo_empty rising on the same cycle: one release, no double pointer advance.
  - rst dominates all other inputs.

Test Plan:
- Reset with rst=1 for 3 cycles, random inputs -> sel=0, fifo_rd=0, data_valid=0, grant_id=0 throughout; first grant after release searches from source 0.
- Only source 1 non-empty, holding 6 words, dst_ready=1:
  - sel=5'b00010 one cycle after fifo_empty[1] falls.
  - 4 consecutive fifo_rd[1] pulses, then sel=0 for 1 cycle.
  - Regrant of source 1 for the remaining 2 words; release when empty.
  - 6 data_valid pulses, each 1 cycle after its pop.
- All 5 FIFOs full, dst_ready=1 -> grant_id sequence 0,1,2,3,4,0, each grant exactly 4 pops separated by one idle cycle; ptr wraps 4->0.
- Source 2 granted, dst_ready dropped for 3 cycles after the 2nd pop -> sel stays 5'b00100, no fifo_rd, no data_valid for those cycles; remaining 2 pops follow after dst_ready=1; total 4.
- Source 3 granted holding only 2 words, source 0 also non-empty -> 2 pops, release on empty, then grant to source 0 (wrap past 4), no pop of the empty FIFO.
- rst pulsed mid-burst on source 4 after 1 pop -> sel, fifo_rd and data_valid drop asynchronously in the same cycle; the pending data_valid is lost; after release the next grant comes from the lowest non-empty index starting at 0.
